reg16_serial_reader: RTL and testbench
======================================

Name: reg16_serial_reader

Overview:
- Reader side of the 16-bit load register: snapshots the register's parallel output on request and streams it out serially, one bit per bit-period.
- Sits between a 16-bit storage register and a serial consumer (debug/scan port, bit-serial ALU feed).
- Controlled by a start/busy/done handshake.
- Snapshot isolates the output stream from later loads into the source register.

Parameters:
- WIDTH, 16, word width in bits; >= 2.
- DIV, 1, clock cycles each bit is held on sout; >= 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- q_in  in  WIDTH  parallel output of source register (its q)
- start  in  1  read request, sampled on rising clk
- sout  out  1  serial data bit
- sout_valid  out  1  high while sout carries a payload bit
- bit_idx  out  $clog2(WIDTH)  index (in q_in numbering) of bit on sout
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last bit period

Behaviour:
- Reset (async, any state): state=IDLE; sout=0, sout_valid=0, bit_idx=0, busy=0, done=0; snapshot and counters cleared. No partial word resumes after reset release.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge N -> snapshot<=q_in, state<=SHIFT, busy<=1, sout_valid<=1, div_cnt<=0, bit_cnt<=0.
  - sout<=first bit: q_in[WIDTH-1] if MSB_FIRST, else q_in[0].
  - bit_idx<=index of that bit.
  - start=0: remain IDLE, outputs held at reset values.
- SHIFT: each bit held exactly DIV cycles.
  - div_cnt counts 0..DIV-1.
  - At div_cnt==DIV-1 and bit_cnt<WIDTH-1: bit_cnt++, div_cnt<=0, sout/bit_idx advance to next bit (descending if MSB_FIRST, else ascending).
  - At div_cnt==DIV-1 and bit_cnt==WIDTH-1: state<=DONE, sout_valid<=0, sout<=0, done<=1.
- DONE: exactly one cycle. done=1, busy=1. Next edge: done<=0, busy<=0, state<=IDLE.
- Timing: sout_valid high for cycles after edges N .. N+WIDTH*DIV-1; done high after edge N+WIDTH*DIV; next start accepted at edge N+WIDTH*DIV+1 or later.
- start while SHIFT or DONE: ignored; no queuing, no restart.
- q_in changes after the capture edge: no effect on the current word; sout comes only from the snapshot.
- Counter widths: bit_cnt $clog2(WIDTH); div_cnt $clog2(DIV) bits, minimum 1. No wrap other than the explicit resets above.
- All outputs registered; no combinational path from start or q_in to any output.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH default of 16, shared with the register and ALU blocks.
- One natural sub-module: bit_period_counter (div_cnt with terminal-count output). Shift/snapshot logic and FSM stay in the top module.

Test Plan:
- Basic read: WIDTH=16, DIV=1, MSB_FIRST=1, q_in=16'hA5C3, start pulse at edge 0 -> sout over 16 cycles = 1010010111000011; bit_idx 15..0; done high after edge 16; busy low after edge 17.
- Bit-period stretch: DIV=3, q_in=16'h8001 -> sout high cycles 0-2, low cycles 3-44, high cycles 45-47; done after edge 48.
- LSB first: MSB_FIRST=0, q_in=16'h0003 -> first two bits 1,1, remaining 14 bits 0; bit_idx 0..15.
- Snapshot isolation and ignored start: change q_in to 16'hFFFF after the capture edge and pulse start at cycles 5 and 16 (DONE cycle) -> stream still 16'hA5C3; exactly one done pulse; a start at cycle 17 is accepted.
- Async reset mid-word: assert rst between edges during bit 7 -> all outputs 0 immediately, before any clock edge. Release rst, then start with q_in=16'h1234 -> full fresh 16-bit stream 0001001000110100.
- Idle stability: no start for 50 cycles after reset -> sout=0, sout_valid=0, busy=0, done=0 throughout.

Source files
------------

// File: rtl/reg16_serial_reader_pkg.sv
// Shared definitions for the 16-bit register family: FSM encodings,
// default word width and a counter-width helper.
package reg16_serial_reader_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg16_serial_reader_if.sv
// Bundle of the parallel-in / serial-out signals around the reader.
// The master side owns the request and source word, the slave side is
// the reader itself.
interface reg16_serial_reader_if
  import reg16_serial_reader_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int IDXW = $clog2(WIDTH);

  logic [WIDTH-1:0] q_in;
  logic             start;
  logic             sout;
  logic             sout_valid;
  logic [IDXW-1:0]  bit_idx;
  logic             busy;
  logic             done;

  modport master (
    output q_in, start,
    input  sout, sout_valid, bit_idx, busy, done
  );

  modport slave (
    input  q_in, start,
    output sout, sout_valid, bit_idx, busy, done
  );

endinterface

// File: rtl/reg16_serial_reader_bit_period_counter.sv
// Bit-period counter: counts 0..DIV-1 while enabled and flags the last
// cycle of each bit period. Wraps to 0 on its own at terminal count.
module reg16_serial_reader_bit_period_counter
  import reg16_serial_reader_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] TC_VAL = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  assign tc_o = (div_cnt_q == TC_VAL);

  // Next count: clear has priority, otherwise step and wrap at terminal count.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear_i) begin
      div_cnt_d = '0;
    end else if (en_i) begin
      div_cnt_d = tc_o ? '0 : div_cnt_q + CW'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/reg16_serial_reader.sv
// Serial reader for the load register: on start it snapshots q_in and
// shifts the snapshot out one bit per DIV-cycle period, then pulses done.
module reg16_serial_reader
  import reg16_serial_reader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  reg16_serial_reader_if.slave bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] FIRST_IDX = MSB_FIRST ? IDXW'(WIDTH - 1) : '0;
  localparam logic [IDXW-1:0] LAST_CNT  = IDXW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [IDXW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDXW-1:0]  bit_idx_q, bit_idx_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDXW-1:0]  next_idx;
  logic             last_bit;
  logic             div_clr;
  logic             div_en;
  logic             div_tc;

  assign last_bit = (bit_cnt_q == LAST_CNT);
  assign next_idx = MSB_FIRST ? (bit_idx_q - IDXW'(1)) : (bit_idx_q + IDXW'(1));

  // Holding the counter at zero outside SHIFT gives the first bit a full period.
  assign div_clr = (state_q != ST_SHIFT);
  assign div_en  = (state_q == ST_SHIFT);

  reg16_serial_reader_bit_period_counter #(
    .DIV (DIV)
  ) u_bit_period_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (div_clr),
    .en_i    (div_en),
    .tc_o    (div_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (div_tc && last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the snapshot, bit counter and registered outputs.
  always_comb begin
    snap_d       = snap_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d    = '0;
        bit_idx_d    = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        if (bus.start) begin
          snap_d       = bus.q_in;
          bit_idx_d    = FIRST_IDX;
          sout_d       = bus.q_in[FIRST_IDX];
          sout_valid_d = 1'b1;
          busy_d       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_tc) begin
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + IDXW'(1);
            bit_idx_d = next_idx;
            sout_d    = snap_q[next_idx];
          end else begin
            bit_idx_d    = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            done_d       = 1'b1;
          end
        end
      end
      ST_DONE: begin
        bit_cnt_d = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
      end
      default: begin
        bit_cnt_d    = '0;
        bit_idx_d    = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
      end
    endcase
  end

  // Snapshot, bit counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q       <= '0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_reg16_serial_reader.sv
// Scoreboard bench: three reader instances (DIV=1 MSB first, DIV=3 MSB
// first, DIV=1 LSB first). Stimulus pushes expected {bit_idx, sout} per
// cycle and expected done pulses; a negedge monitor pops and compares.
module tb_reg16_serial_reader;
  import reg16_serial_reader_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg16_serial_reader_if #(.WIDTH(W)) bus_a ();
  reg16_serial_reader_if #(.WIDTH(W)) bus_b ();
  reg16_serial_reader_if #(.WIDTH(W)) bus_c ();

  reg16_serial_reader #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  reg16_serial_reader #(.WIDTH(W), .DIV(3), .MSB_FIRST(1'b1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );
  reg16_serial_reader #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b0)) dut_c (
    .clk (clk), .rst (rst), .bus (bus_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [4:0] exp_c[$];
  int         done_exp[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // seq holds the hand-computed stream in emission order (seq[15] first).
  task automatic push_word(input int inst, input logic [15:0] seq, input int div, input bit msb);
    logic [3:0] idx;
    for (int k = 0; k < W; k++) begin
      idx = msb ? 4'(W - 1 - k) : 4'(k);
      for (int r = 0; r < div; r++) begin
        case (inst)
          0: exp_a.push_back({idx, seq[15-k]});
          1: exp_b.push_back({idx, seq[15-k]});
          default: exp_c.push_back({idx, seq[15-k]});
        endcase
      end
    end
    done_exp[inst]++;
  endtask

  task automatic pop_exp(input int inst, output bit ok, output logic [4:0] val);
    ok  = 1'b0;
    val = '0;
    case (inst)
      0: if (exp_a.size() > 0) begin val = exp_a.pop_front(); ok = 1'b1; end
      1: if (exp_b.size() > 0) begin val = exp_b.pop_front(); ok = 1'b1; end
      default: if (exp_c.size() > 0) begin val = exp_c.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic logic busy_of(input int inst);
    case (inst)
      0:       return bus_a.busy;
      1:       return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  task automatic wait_idle(input int inst, input int budget);
    int cnt = 0;
    while (busy_of(inst) && cnt < budget) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (busy_of(inst)) begin
      n_fail++;
      $display("FAIL wait_idle inst=%0d: still busy after %0d cycles", inst, budget);
    end
  endtask

  // Monitor: compare every payload bit and every done pulse against the scoreboard.
  always @(negedge clk) begin
    logic [4:0] obs [3];
    logic [2:0] v;
    logic [2:0] d;
    logic [4:0] e;
    bit         ok;
    obs[0] = {bus_a.bit_idx, bus_a.sout};
    obs[1] = {bus_b.bit_idx, bus_b.sout};
    obs[2] = {bus_c.bit_idx, bus_c.sout};
    v = {bus_c.sout_valid, bus_b.sout_valid, bus_a.sout_valid};
    d = {bus_c.done, bus_b.done, bus_a.done};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (v[i]) begin
        pop_exp(i, ok, e);
        if (!ok) begin
          n_fail++;
          $display("FAIL sb_unexpected_bit inst=%0d: got idx=%0d sout=%0b expected no payload",
                   i, obs[i][4:1], obs[i][0]);
        end else if (obs[i] !== e) begin
          n_fail++;
          $display("FAIL sb_bit inst=%0d: got idx=%0d sout=%0b expected idx=%0d sout=%0b",
                   i, obs[i][4:1], obs[i][0], e[4:1], e[0]);
        end
      end else if (obs[i][0] !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_idle_sout inst=%0d: got sout=%0b expected 0", i, obs[i][0]);
      end
      if (d[i]) begin
        n_checks++;
        if (done_exp[i] == 0) begin
          n_fail++;
          $display("FAIL sb_done inst=%0d: got done=1 expected no pulse", i);
        end else begin
          done_exp[i]--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) done_exp[i] = 0;
    rst = 1'b1;
    bus_a.q_in = '0; bus_a.start = 1'b0;
    bus_b.q_in = '0; bus_b.start = 1'b0;
    bus_c.q_in = '0; bus_c.start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset_a", {bus_a.sout, bus_a.sout_valid, bus_a.busy, bus_a.done, bus_a.bit_idx}, 0);
    check("reset_b", {bus_b.sout, bus_b.sout_valid, bus_b.busy, bus_b.done, bus_b.bit_idx}, 0);
    check("reset_c", {bus_c.sout, bus_c.sout_valid, bus_c.busy, bus_c.done, bus_c.bit_idx}, 0);
    rst = 1'b0;

    // Idle stability: 50 cycles without start
    for (int c = 0; c < 50; c++) begin
      tick();
      check("idle_a", {bus_a.sout, bus_a.sout_valid, bus_a.busy, bus_a.done}, 0);
    end

    // Basic read with snapshot isolation and ignored starts
    bus_a.q_in  = 16'hA5C3;
    bus_a.start = 1'b1;
    push_word(0, 16'b1010010111000011, 1, 1'b1);
    tick();  // after edge 0
    check("first_busy", bus_a.busy, 1);
    check("first_idx", bus_a.bit_idx, 15);
    bus_a.start = 1'b0;
    bus_a.q_in  = 16'hFFFF;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 4) bus_a.start = 1'b1;
      if (e == 5) bus_a.start = 1'b0;
      if (e == 15) begin
        check("last_bit_idx", bus_a.bit_idx, 0);
        check("last_bit_done", bus_a.done, 0);
      end
      if (e == 16) begin
        check("done_edge16", {bus_a.done, bus_a.busy, bus_a.sout_valid}, 3'b110);
        bus_a.start = 1'b1;  // held through the DONE cycle
      end
    end
    tick();  // edge 17: start seen in DONE is ignored
    check("edge17_idle", {bus_a.done, bus_a.busy, bus_a.sout_valid}, 3'b000);
    push_word(0, 16'hFFFF, 1, 1'b1);
    tick();  // edge 18: accepted from IDLE
    check("restart_busy", bus_a.busy, 1);
    bus_a.start = 1'b0;
    wait_idle(0, 40);
    tick();

    // Asynchronous reset during bit 7
    bus_a.q_in  = 16'hA5C3;
    bus_a.start = 1'b1;
    push_word(0, 16'b1010010111000011, 1, 1'b1);
    tick();
    bus_a.start = 1'b0;
    repeat (7) tick();
    check("bit7_idx", bus_a.bit_idx, 8);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {bus_a.sout, bus_a.sout_valid, bus_a.busy, bus_a.done, bus_a.bit_idx}, 0);
    exp_a.delete();
    done_exp[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("no_resume", {bus_a.sout_valid, bus_a.busy, bus_a.done}, 0);
    bus_a.q_in  = 16'h1234;
    bus_a.start = 1'b1;
    push_word(0, 16'b0001001000110100, 1, 1'b1);
    tick();
    bus_a.start = 1'b0;
    wait_idle(0, 40);

    // Bit-period stretch, DIV=3
    bus_b.q_in  = 16'h8001;
    bus_b.start = 1'b1;
    push_word(1, 16'b1000000000000001, 3, 1'b1);
    tick();  // edge 0
    bus_b.start = 1'b0;
    bus_b.q_in  = 16'h0000;
    for (int e = 1; e <= 49; e++) begin
      tick();
      if (e == 47) check("b_edge47", {bus_b.done, bus_b.sout_valid, bus_b.sout}, 3'b011);
      if (e == 48) check("b_edge48", {bus_b.done, bus_b.busy, bus_b.sout_valid}, 3'b110);
      if (e == 49) check("b_edge49", {bus_b.done, bus_b.busy}, 2'b00);
    end

    // LSB first
    bus_c.q_in  = 16'h0003;
    bus_c.start = 1'b1;
    push_word(2, 16'b1100000000000000, 1, 1'b0);
    tick();
    check("c_first_idx", bus_c.bit_idx, 0);
    bus_c.start = 1'b0;
    wait_idle(2, 40);

    repeat (3) tick();
    check("a_queue_empty", exp_a.size(), 0);
    check("b_queue_empty", exp_b.size(), 0);
    check("c_queue_empty", exp_c.size(), 0);
    check("a_done_seen", done_exp[0], 0);
    check("b_done_seen", done_exp[1], 0);
    check("c_done_seen", done_exp[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
